// File: rtl/low_araddr_rdata_align.sv
// Realigns AXI R beats to the byte offset dropped when the AR was issued aligned.
// One offset is popped from the low-araddr FIFO per read burst.
module low_araddr_rdata_align #(
    parameter int DATA_WIDTH = 128,
    parameter int OFS_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ofs_rd_en,
    input  logic                  ofs_rd_vld,
    input  logic [OFS_WIDTH-1:0]  ofs_rd_data,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_rvalid,
    input  logic                  s_rlast,
    output logic                  s_rready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        PASS,
        FIRST,
        STREAM,
        FLUSH
    } state_t;

    state_t                state;
    logic [OFS_WIDTH-1:0]  ofs_q;
    logic [DATA_WIDTH-1:0] hold_q;

    logic                  out_free;
    logic                  r_acc;
    logic [2*DATA_WIDTH-1:0] cat_m;
    logic [2*DATA_WIDTH-1:0] cat_f;
    logic [DATA_WIDTH-1:0] merge_w;
    logic [DATA_WIDTH-1:0] flush_w;

    assign out_free  = !m_valid || m_ready;
    assign ofs_rd_en = (state == IDLE) && ofs_rd_vld;
    assign r_acc     = s_rvalid && s_rready;

    always_comb begin
        s_rready = 1'b0;
        unique case (state)
            PASS:    s_rready = out_free;
            FIRST:   s_rready = 1'b1;
            STREAM:  s_rready = out_free;
            default: s_rready = 1'b0;
        endcase
    end

    // Output byte i is byte (i + ofs_q) of the {new, hold} pair.
    assign cat_m = {s_rdata, hold_q};
    assign cat_f = {{DATA_WIDTH{1'b0}}, hold_q};

    always_comb begin
        merge_w = '0;
        flush_w = '0;
        for (int i = 0; i < NB; i++) begin
            merge_w[8*i +: 8] = cat_m[8*(i + int'(ofs_q)) +: 8];
            flush_w[8*i +: 8] = cat_f[8*(i + int'(ofs_q)) +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ofs_q   <= '0;
            hold_q  <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (ofs_rd_vld) begin
                        ofs_q <= ofs_rd_data;
                        state <= (ofs_rd_data == '0) ? PASS : FIRST;
                    end
                end
                PASS: begin
                    if (r_acc) begin
                        m_data  <= s_rdata;
                        m_last  <= s_rlast;
                        m_valid <= 1'b1;
                        if (s_rlast) begin
                            state <= IDLE;
                        end
                    end
                end
                FIRST: begin
                    if (r_acc) begin
                        hold_q <= s_rdata;
                        state  <= s_rlast ? FLUSH : STREAM;
                    end
                end
                STREAM: begin
                    if (r_acc) begin
                        m_data  <= merge_w;
                        m_last  <= 1'b0;
                        m_valid <= 1'b1;
                        hold_q  <= s_rdata;
                        if (s_rlast) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        m_data  <= flush_w;
                        m_last  <= 1'b1;
                        m_valid <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
